canvas_cursor_ctrl: RTL and testbench

Cursor/paint sequencer for the canvas. Conditions the four direction buttons (two-flop synchronizer, debounce, rising-edge detect), moves a wrapping cursor over a 2^X_BITS × 2^Y_BITS pixel grid, and issues one valid/ready pixel-write per move or stamp to the framebuffer. The colour is the brush/eraser colour mix. Sits between the raw pad inputs and the framebuffer write port.

---
 rtl/canvas_cursor_ctrl.sv | 140 ++++++++++++++
 tb/tb_canvas_cursor_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/canvas_cursor_ctrl.sv
// Cursor/paint sequencer: conditions the four direction buttons, moves a
// wrapping cursor over the pixel grid and issues one valid/ready pixel
// write per painted move or stamp.
module canvas_cursor_ctrl #(
    parameter int X_BITS   = 4,
    parameter int Y_BITS   = 4,
    parameter int DEBOUNCE = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [3:0]                 buttons,
    input  logic [2:0]                 rgb_sel,
    input  logic                       brush,
    input  logic                       paint_en,
    input  logic                       stamp,
    output logic                       wr_valid,
    input  logic                       wr_ready,
    output logic [X_BITS+Y_BITS-1:0]   wr_addr,
    output logic [2:0]                 wr_data,
    output logic [X_BITS-1:0]          cur_x,
    output logic [Y_BITS-1:0]          cur_y,
    output logic                       busy
);

    localparam logic [7:0]        DEB_LAST = 8'(DEBOUNCE - 1);
    localparam logic [X_BITS-1:0] X_ONE    = X_BITS'(1);
    localparam logic [Y_BITS-1:0] Y_ONE    = Y_BITS'(1);

    typedef enum logic {IDLE, WRITE} state_t;

    logic [3:0] sync1_reg, sync_reg;
    logic [3:0] deb_level;
    logic [3:0] deb_d_reg;
    logic [3:0] rise_reg;

    state_t                     state_reg, state_next;
    logic [X_BITS-1:0]          cur_x_reg, cur_x_next;
    logic [Y_BITS-1:0]          cur_y_reg, cur_y_next;
    logic [X_BITS+Y_BITS-1:0]   wr_addr_reg, wr_addr_next;
    logic [2:0]                 wr_data_reg, wr_data_next;
    logic [2:0]                 col;

    // Two-flop synchronizer, debounced-level delay and press-edge register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_reg <= 4'b0000;
            sync_reg  <= 4'b0000;
            deb_d_reg <= 4'b0000;
            rise_reg  <= 4'b0000;
        end else begin
            sync1_reg <= buttons;
            sync_reg  <= sync1_reg;
            deb_d_reg <= deb_level;
            rise_reg  <= deb_level & ~deb_d_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_debounce
            logic [7:0] cnt_reg;
            logic       deb_reg;

            // Accept a new level only after it persists for DEBOUNCE cycles
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt_reg <= 8'd0;
                    deb_reg <= 1'b0;
                end else if (sync_reg[gi] == deb_reg) begin
                    cnt_reg <= 8'd0;
                end else if (cnt_reg == DEB_LAST) begin
                    deb_reg <= sync_reg[gi];
                    cnt_reg <= 8'd0;
                end else begin
                    cnt_reg <= cnt_reg + 8'd1;
                end
            end

            assign deb_level[gi] = deb_reg;
        end
    endgenerate

    assign col = brush ? rgb_sel : 3'b000;

    // State, cursor and captured write registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cur_x_reg   <= '0;
            cur_y_reg   <= '0;
            wr_addr_reg <= '0;
            wr_data_reg <= 3'b000;
        end else begin
            state_reg   <= state_next;
            cur_x_reg   <= cur_x_next;
            cur_y_reg   <= cur_y_next;
            wr_addr_reg <= wr_addr_next;
            wr_data_reg <= wr_data_next;
        end
    end

    // Next-state logic: prioritised move (Up > Down > Right > Left), stamp, handshake
    always_comb begin
        state_next   = state_reg;
        cur_x_next   = cur_x_reg;
        cur_y_next   = cur_y_reg;
        wr_addr_next = wr_addr_reg;
        wr_data_next = wr_data_reg;
        case (state_reg)
            IDLE: begin
                if (|rise_reg) begin
                    if (rise_reg[3])      cur_y_next = cur_y_reg - Y_ONE;
                    else if (rise_reg[2]) cur_y_next = cur_y_reg + Y_ONE;
                    else if (rise_reg[1]) cur_x_next = cur_x_reg + X_ONE;
                    else                  cur_x_next = cur_x_reg - X_ONE;
                    if (paint_en) begin
                        wr_addr_next = {cur_y_next, cur_x_next};
                        wr_data_next = col;
                        state_next   = WRITE;
                    end
                end else if (stamp) begin
                    wr_addr_next = {cur_y_reg, cur_x_reg};
                    wr_data_next = col;
                    state_next   = WRITE;
                end
            end
            WRITE: begin
                if (wr_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign wr_valid = (state_reg == WRITE);
    assign busy     = (state_reg == WRITE);
    assign wr_addr  = wr_addr_reg;
    assign wr_data  = wr_data_reg;
    assign cur_x    = cur_x_reg;
    assign cur_y    = cur_y_reg;

endmodule

// File: tb/tb_canvas_cursor_ctrl.sv
// Bench for canvas_cursor_ctrl: directed scenarios plus randomized button
// presses / stamps against a transaction-level cursor and write model.
module tb_canvas_cursor_ctrl;

    localparam int XB = 4;
    localparam int YB = 4;
    localparam int D  = 4;
    localparam int W  = 1 << XB;
    localparam int H  = 1 << YB;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [3:0]     buttons = 4'b0000;
    logic [2:0]     rgb_sel = 3'b000;
    logic           brush = 1'b0;
    logic           paint_en = 1'b0;
    logic           stamp = 1'b0;
    logic           wr_ready = 1'b1;
    logic           wr_valid;
    logic [XB+YB-1:0] wr_addr;
    logic [2:0]     wr_data;
    logic [XB-1:0]  cur_x;
    logic [YB-1:0]  cur_y;
    logic           busy;

    canvas_cursor_ctrl #(.X_BITS(XB), .Y_BITS(YB), .DEBOUNCE(D)) dut (
        .clk(clk), .rst_n(rst_n), .buttons(buttons), .rgb_sel(rgb_sel),
        .brush(brush), .paint_en(paint_en), .stamp(stamp),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .cur_x(cur_x), .cur_y(cur_y), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int mx = 0;
    int my = 0;
    int exp_q[$];
    int got_q[$];
    bit rand_ready = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Handshake capture and stall-stability watch, sampled mid-cycle
    logic             pv = 1'b0, pr = 1'b0, prst = 1'b0;
    logic [XB+YB-1:0] pa = '0;
    logic [2:0]       pd = 3'b000;
    always @(negedge clk) begin
        if (prst && rst_n && pv && !pr) begin
            total++;
            assert (wr_valid === 1'b1 && wr_addr === pa && wr_data === pd) else begin
                bad++;
                $error("FAIL stall_hold observed v=%b a=%0h d=%0h expected v=1 a=%0h d=%0h",
                       wr_valid, wr_addr, wr_data, pa, pd);
            end
        end
        if (rst_n && wr_valid && wr_ready) got_q.push_back(32'({wr_addr, wr_data}));
        pv = wr_valid; pr = wr_ready; prst = rst_n; pa = wr_addr; pd = wr_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) wr_ready = 1'($urandom_range(0, 1));
    endtask

    function automatic int colour();
        return brush ? int'(rgb_sel) : 0;
    endfunction

    function automatic int wr_word(input int x, input int y, input int c);
        return (y * W + x) * 8 + c;
    endfunction

    // Reference: one press of a mask moves by its highest-priority direction
    task automatic model_move(input logic [3:0] mask);
        if (mask[3])      my = (my + H - 1) % H;
        else if (mask[2]) my = (my + 1) % H;
        else if (mask[1]) mx = (mx + 1) % W;
        else              mx = (mx + W - 1) % W;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic compare_q(input string tag);
        check({tag, "_nwrites"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0)
            check({tag, "_write"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_cursor(input string tag);
        check({tag, "_x"}, 32'(cur_x), 32'(mx));
        check({tag, "_y"}, 32'(cur_y), 32'(my));
    endtask

    task automatic press(input logic [3:0] mask, input string tag);
        buttons = mask;
        repeat (D + 6) tick();
        model_move(mask);
        if (paint_en) exp_q.push_back(wr_word(mx, my, colour()));
        check_cursor(tag);
        buttons = 4'b0000;
        repeat (D + 4) tick();
        wait_idle(tag);
        compare_q(tag);
        check_cursor({tag, "_rel"});
    endtask

    task automatic do_stamp(input string tag);
        stamp = 1'b1;
        tick();
        stamp = 1'b0;
        exp_q.push_back(wr_word(mx, my, colour()));
        wait_idle(tag);
        repeat (2) tick();
        compare_q(tag);
        check_cursor(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        mx = 0;
        my = 0;
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_valid", 32'(wr_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_addr", 32'(wr_addr), 32'd0);
        check("rst_data", 32'(wr_data), 32'd0);
        check_cursor("rst");
        rst_n = 1'b1;
        tick();

        // Right held, paint off: exact latency then one move, no write
        paint_en = 1'b0;
        buttons = 4'b0010;
        repeat (3 + D) tick();
        check("lat_before", 32'(cur_x), 32'd0);
        tick();
        check("lat_after", 32'(cur_x), 32'd1);
        mx = 1;
        buttons = 4'b0000;
        repeat (D + 6) tick();
        check_cursor("right_once");
        compare_q("right_nowrite");

        // Painted Left then Up with wrap-around
        paint_en = 1'b1; brush = 1'b1; rgb_sel = 3'b110; wr_ready = 1'b1;
        mx = 1; my = 0;
        press(4'b0001, "left1");
        press(4'b0001, "left_wrap");
        press(4'b1000, "up_wrap");

        // Eraser stamp at (3,5)
        do_reset();
        paint_en = 1'b0;
        repeat (3) press(4'b0010, "to_x3");
        repeat (5) press(4'b0100, "to_y5");
        brush = 1'b0; rgb_sel = 3'b111;
        do_stamp("stamp_erase");

        // Stalled write: inputs change and Down arrives during the stall
        paint_en = 1'b1; brush = 1'b1; rgb_sel = 3'b010; wr_ready = 1'b0;
        buttons = 4'b0010;
        repeat (D + 6) tick();
        buttons = 4'b0000;
        model_move(4'b0010);
        exp_q.push_back(wr_word(mx, my, colour()));
        check("stall_valid", 32'(wr_valid), 32'd1);
        rgb_sel = 3'b101; brush = 1'b0; paint_en = 1'b0;
        buttons = 4'b0100;
        repeat (D + 6) tick();
        buttons = 4'b0000;
        repeat (D + 4) tick();
        check("stall_still_valid", 32'(wr_valid), 32'd1);
        check_cursor("stall_drop_down");
        wr_ready = 1'b1;
        tick();
        check("stall_busy_fall", 32'(busy), 32'd0);
        compare_q("stall");

        // Simultaneous Up+Right, then a short Left glitch
        paint_en = 1'b1; brush = 1'b1; rgb_sel = 3'b011;
        press(4'b1010, "up_right");
        buttons = 4'b0001;
        repeat (2) tick();
        buttons = 4'b0000;
        repeat (D + 8) tick();
        check_cursor("glitch");
        compare_q("glitch");

        // Reset during a stalled write
        wr_ready = 1'b0;
        buttons = 4'b0001;
        repeat (D + 6) tick();
        buttons = 4'b0000;
        check("pre_rst_valid", 32'(wr_valid), 32'd1);
        rst_n = 1'b0;
        tick();
        check("wrst_valid", 32'(wr_valid), 32'd0);
        check("wrst_busy", 32'(busy), 32'd0);
        check("wrst_addr", 32'(wr_addr), 32'd0);
        check("wrst_data", 32'(wr_data), 32'd0);
        mx = 0; my = 0;
        check_cursor("wrst");
        rst_n = 1'b1;
        wr_ready = 1'b1;
        repeat (D + 6) tick();
        got_q.delete();
        exp_q.delete();

        // Randomized presses and stamps with random back-pressure
        rand_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            paint_en = 1'($urandom_range(0, 1));
            brush    = 1'($urandom_range(0, 1));
            rgb_sel  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) do_stamp("rnd_stamp");
            else press(4'($urandom_range(1, 15)), "rnd_press");
        end
        rand_ready = 1'b0;
        wr_ready = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
